// File: rtl/hamming_pkg.sv
// -----------------------------------------------------------------------------
// hamming_pkg
//   Shared definitions for the Hamming(16,11) SECDED encoder engine and any
//   bench or decoder that needs the same codeword layout.
//
//   Contents:
//     state_t        : encoder engine FSM states
//     DEF_*          : default engine parameters (message count, base addresses)
//     CW_*           : bit positions inside the 16-bit codeword
//
//   Codeword layout (bit 15 .. bit 0):
//     {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0}
//   Bits 1..15 follow classic Hamming positions (parity bits at powers of
//   two); bit 0 holds the overall parity used for double-error detection.
// -----------------------------------------------------------------------------
package hamming_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD_LO = 3'd1,
      ST_RD_HI = 3'd2,
      ST_WR_LO = 3'd3,
      ST_WR_HI = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   localparam int         DEF_NUM_MSG  = 15;
   localparam logic [7:0] DEF_IN_BASE  = 8'd0;
   localparam logic [7:0] DEF_OUT_BASE = 8'd30;

   // Single-bit fields.
   localparam int CW_P0 = 0;
   localparam int CW_P1 = 1;
   localparam int CW_P2 = 2;
   localparam int CW_D1 = 3;
   localparam int CW_P4 = 4;
   localparam int CW_P8 = 8;

   // Multi-bit data fields: LSB position and width.
   localparam int CW_D4_2_LO  = 5;   // d[4:2]  -> codeword[7:5]
   localparam int CW_D4_2_W   = 3;
   localparam int CW_D11_5_LO = 9;   // d[11:5] -> codeword[15:9]
   localparam int CW_D11_5_W  = 7;

endpackage : hamming_pkg

// File: rtl/hamming_enc_engine_if.sv
// -----------------------------------------------------------------------------
// hamming_enc_engine_if
//   Byte-wide data memory port used by the Hamming encoder engine.
//
//   Signals:
//     mem_addr  [7:0] : byte address for the current read or write
//     mem_rdata [7:0] : read data, combinational from mem_addr
//     mem_wdata [7:0] : byte to be written
//     mem_we          : write strobe, memory captures on the rising clk edge
//
//   Modports:
//     master : the engine (drives address / write data / strobe)
//     slave  : the memory (returns read data)
// -----------------------------------------------------------------------------
interface hamming_enc_engine_if;

   logic [7:0] mem_addr;
   logic [7:0] mem_rdata;
   logic [7:0] mem_wdata;
   logic       mem_we;

   modport master (
      output mem_addr,
      output mem_wdata,
      output mem_we,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr,
      input  mem_wdata,
      input  mem_we,
      output mem_rdata
   );

endinterface : hamming_enc_engine_if

// File: rtl/hamming_enc11.sv
// -----------------------------------------------------------------------------
// hamming_enc11
//   Purely combinational Hamming(16,11) SECDED encoder.
//
//   Ports:
//     d        [11:1] in  : 11 data bits, numbered d1..d11
//     codeword [15:0] out : {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0}
//
//   p0 is the overall parity over all data and Hamming parity bits, so the
//   whole 16-bit codeword always has even parity.
// -----------------------------------------------------------------------------
module hamming_enc11
   import hamming_pkg::*;
(
   input  logic [11:1] d,
   output logic [15:0] codeword
);

   logic p8, p4, p2, p1, p0;

   assign p8 = ^d[11:5];
   assign p4 = (^d[11:8]) ^ (^d[4:2]);
   assign p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
   assign p1 = d[11] ^ d[9]  ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
   assign p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;

   // NOTE: every signal assigned in an always_comb gets a default first;
   // a path that leaves it unassigned would infer a latch.
   always_comb begin
      codeword = '0;
      codeword[CW_D11_5_LO +: CW_D11_5_W] = d[11:5];
      codeword[CW_P8]                     = p8;
      codeword[CW_D4_2_LO +: CW_D4_2_W]   = d[4:2];
      codeword[CW_P4]                     = p4;
      codeword[CW_D1]                     = d[1];
      codeword[CW_P2]                     = p2;
      codeword[CW_P1]                     = p1;
      codeword[CW_P0]                     = p0;
   end

endmodule : hamming_enc11

// File: rtl/hamming_enc_engine.sv
// -----------------------------------------------------------------------------
// hamming_enc_engine
//   Reads NUM_MSG 11-bit messages from a byte memory, encodes each one into a
//   16-bit SECDED codeword and writes the codewords back to memory.
//
//   Message i   : low byte  at IN_BASE+2i   = d[8:1]
//                 high byte at IN_BASE+2i+1 = {xxxxx, d[11:9]} (upper bits ignored)
//   Codeword i  : low byte  at OUT_BASE+2i, high byte at OUT_BASE+2i+1
//
//   Every message takes exactly four cycles (RD_LO, RD_HI, WR_LO, WR_HI), so
//   done rises 4*NUM_MSG cycles after the cycle in which start was sampled.
//
//   Ports:
//     clk    in  : clock, all state changes on the rising edge
//     reset  in  : synchronous active-low reset
//     start  in  : one-cycle run request, honoured only in IDLE or DONE
//     done   out : high while in DONE, until the next accepted start or reset
//     bus    --  : memory port (hamming_enc_engine_if.master)
// -----------------------------------------------------------------------------
module hamming_enc_engine
   import hamming_pkg::*;
#(
   parameter int         NUM_MSG  = DEF_NUM_MSG,
   parameter logic [7:0] IN_BASE  = DEF_IN_BASE,
   parameter logic [7:0] OUT_BASE = DEF_OUT_BASE
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   output logic                 done,
   hamming_enc_engine_if.master bus
);

   localparam int               IDX_W    = $clog2(NUM_MSG) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MSG - 1);

   state_t           state_q;
   state_t           state_d;
   logic [IDX_W-1:0] idx_q;
   logic [11:1]      data_q;
   logic [15:0]      codeword;
   logic [7:0]       msg_off;
   logic             last_msg;
   logic             unused_rdata_hi;

   // Byte offset of message i inside either buffer; wraps modulo 256.
   assign msg_off  = 8'({idx_q, 1'b0});
   assign last_msg = (idx_q >= LAST_IDX);

   // The top five bits of each message's high byte carry no data.
   assign unused_rdata_hi = ^bus.mem_rdata[7:3];

   hamming_enc11 u_enc (
      .d        (data_q),
      .codeword (codeword)
   );

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state is updated with non-blocking assignments so every
   // flop samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE,
         ST_DONE:  if (start) state_d = ST_RD_LO;
         ST_RD_LO: state_d = ST_RD_HI;
         ST_RD_HI: state_d = ST_WR_LO;
         ST_WR_LO: state_d = ST_WR_HI;
         ST_WR_HI: state_d = last_msg ? ST_DONE : ST_RD_LO;
         default:  state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Message index and captured data
   //   The data register is reset too, so a run aborted mid-message never
   //   leaves stale bits feeding the encoder.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         idx_q  <= '0;
         data_q <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE,
            ST_DONE:  if (start) idx_q <= '0;
            ST_RD_LO: data_q[8:1]  <= bus.mem_rdata;
            ST_RD_HI: data_q[11:9] <= bus.mem_rdata[2:0];
            ST_WR_HI: if (!last_msg) idx_q <= idx_q + 1'b1;
            default:  ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs (Moore: decoded from the current state only)
   // ---------------------------------------------------------------------------
   always_comb begin
      bus.mem_addr  = 8'd0;
      bus.mem_wdata = 8'd0;
      bus.mem_we    = 1'b0;
      done          = 1'b0;
      unique case (state_q)
         ST_RD_LO: bus.mem_addr = IN_BASE + msg_off;
         ST_RD_HI: bus.mem_addr = IN_BASE + msg_off + 8'd1;
         ST_WR_LO: begin
            bus.mem_addr  = OUT_BASE + msg_off;
            bus.mem_wdata = codeword[7:0];
            bus.mem_we    = 1'b1;
         end
         ST_WR_HI: begin
            bus.mem_addr  = OUT_BASE + msg_off + 8'd1;
            bus.mem_wdata = codeword[15:8];
            bus.mem_we    = 1'b1;
         end
         ST_DONE:  done = 1'b1;
         default:  ;
      endcase
   end

endmodule : hamming_enc_engine

// File: tb/tb_hamming_enc_engine.sv
// -----------------------------------------------------------------------------
// tb_hamming_enc_engine
//   Self-checking bench for hamming_enc_engine with a 256-byte memory model.
//   Expected codewords come from a position-based Hamming model: data bits
//   fill the non-power-of-two positions 3,5,6,7,9..15, each parity bit at
//   position 2^k covers every position with bit k set, and bit 0 makes the
//   whole word even.
// -----------------------------------------------------------------------------
module tb_hamming_enc_engine;

   localparam int NUM      = 15;
   localparam int IN_BASE  = 0;
   localparam int OUT_BASE = 30;
   localparam int RUN_LEN  = 4 * NUM;

   typedef struct {
      logic [7:0] lo;
      logic [7:0] hi;
      logic [7:0] exp_lo;
      logic [7:0] exp_hi;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   logic start;
   logic done;

   logic       tb_we   = 1'b0;
   logic [7:0] tb_addr = 8'd0;
   logic [7:0] tb_data = 8'd0;

   logic [7:0]  mem [256];
   int          wr_count = 0;
   logic [10:0] msg [NUM];   // msg[i][0] is d1
   vec_t        vecs [6];

   int n_cmp  = 0;
   int n_fail = 0;

   hamming_enc_engine_if bus ();

   hamming_enc_engine dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .done  (done),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Memory model: combinational read, write on the rising edge. The bench
   // loads data only while the engine is idle.
   assign bus.mem_rdata = mem[bus.mem_addr];

   always @(posedge clk) begin
      if (tb_we) begin
         mem[tb_addr] <= tb_data;
      end else if (bus.mem_we) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
         wr_count          <= wr_count + 1;
      end
   end

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   function automatic bit is_pow2(input int p);
      return (p & (p - 1)) == 0;
   endfunction

   function automatic logic [15:0] ref_enc(input logic [10:0] d);
      logic [15:0] cw = '0;
      int          k  = 0;
      for (int pos = 1; pos < 16; pos++) begin
         if (!is_pow2(pos)) begin
            cw[pos] = d[k];
            k++;
         end
      end
      for (int p = 1; p < 16; p = p * 2) begin
         for (int pos = 1; pos < 16; pos++) begin
            if (((pos & p) != 0) && (pos != p)) cw[p] = cw[p] ^ cw[pos];
         end
      end
      cw[0] = ^cw[15:1];
      return cw;
   endfunction

   // SECDED decode: {status[1:0], 3'b000, d[11:1]}; status 01 = corrected,
   // 10 = double error detected.
   function automatic logic [15:0] ref_dec(input logic [15:0] cw);
      logic [15:0] c      = cw;
      logic [1:0]  status = 2'b00;
      logic [10:0] d      = '0;
      int          syn    = 0;
      int          k      = 0;
      for (int pos = 1; pos < 16; pos++) if (c[pos]) syn = syn ^ pos;
      if (^c) begin
         c[syn] = ~c[syn];
         status = 2'b01;
      end else if (syn != 0) begin
         status = 2'b10;
      end
      for (int pos = 1; pos < 16; pos++) begin
         if (!is_pow2(pos)) begin
            d[k] = c[pos];
            k++;
         end
      end
      return {status, 3'b000, d};
   endfunction

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic write_byte(input int addr, input logic [7:0] data);
      tb_we   = 1'b1;
      tb_addr = 8'(addr);
      tb_data = data;
      @(negedge clk);
      tb_we   = 1'b0;
   endtask

   // Random messages with garbage in the ignored upper bits of each high byte.
   task automatic load_random();
      for (int i = 0; i < NUM; i++) begin
         msg[i] = 11'($urandom);
         write_byte(IN_BASE + 2 * i, msg[i][7:0]);
         write_byte(IN_BASE + 2 * i + 1, {5'($urandom), msg[i][10:8]});
      end
   endtask

   task automatic fill_out(input logic [7:0] val);
      for (int a = OUT_BASE; a < OUT_BASE + 2 * NUM; a++) write_byte(a, val);
   endtask

   // Pulse start, then count cycles until done (bounded). Optionally pulse a
   // second start extra_at cycles into the run.
   task automatic run_engine(input int extra_at, output int cycles);
      int  n    = 0;
      bit  seen = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!seen && n < 4 * RUN_LEN) begin
         @(negedge clk);
         n++;
         start = (n == extra_at);
         if (done) seen = 1'b1;
      end
      start  = 1'b0;
      cycles = seen ? n : -1;
   endtask

   task automatic check_outputs(input string tag);
      logic [15:0] cw;
      for (int i = 0; i < NUM; i++) begin
         cw = ref_enc(msg[i]);
         check($sformatf("%s lo[%0d]", tag, i), 32'(mem[OUT_BASE + 2 * i]), 32'(cw[7:0]));
         check($sformatf("%s hi[%0d]", tag, i), 32'(mem[OUT_BASE + 2 * i + 1]), 32'(cw[15:8]));
      end
   endtask

   // ---------------------------------------------------------------------------
   // Test sequence
   // ---------------------------------------------------------------------------
   initial begin
      int cycles;
      int w0;
      bit hit;

      vecs[0] = '{lo: 8'h00, hi: 8'h00, exp_lo: 8'h00, exp_hi: 8'h00};
      vecs[1] = '{lo: 8'hFF, hi: 8'h07, exp_lo: 8'hFF, exp_hi: 8'hFF};
      vecs[2] = '{lo: 8'h01, hi: 8'h00, exp_lo: 8'h0F, exp_hi: 8'h00};
      vecs[3] = '{lo: 8'h00, hi: 8'h04, exp_lo: 8'h17, exp_hi: 8'h81};
      vecs[4] = '{lo: 8'hFF, hi: 8'hFF, exp_lo: 8'hFF, exp_hi: 8'hFF};
      vecs[5] = '{lo: 8'h00, hi: 8'hFC, exp_lo: 8'h17, exp_hi: 8'h81};

      reset = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;

      check("reset done",  32'(done),          32'd0);
      check("reset we",    32'(bus.mem_we),    32'd0);
      check("reset addr",  32'(bus.mem_addr),  32'd0);
      check("reset wdata", 32'(bus.mem_wdata), 32'd0);

      // Run 1: table vectors in slots 0..5, random in the rest.
      load_random();
      for (int v = 0; v < 6; v++) begin
         msg[v] = {vecs[v].hi[2:0], vecs[v].lo};
         write_byte(IN_BASE + 2 * v, vecs[v].lo);
         write_byte(IN_BASE + 2 * v + 1, vecs[v].hi);
      end
      w0 = wr_count;
      run_engine(0, cycles);
      check("run1 latency", 32'(cycles), 32'(RUN_LEN));
      check("run1 writes",  32'(wr_count - w0), 32'(2 * NUM));
      for (int v = 0; v < 6; v++) begin
         check($sformatf("vec%0d lo", v), 32'(mem[OUT_BASE + 2 * v]), 32'(vecs[v].exp_lo));
         check($sformatf("vec%0d hi", v), 32'(mem[OUT_BASE + 2 * v + 1]), 32'(vecs[v].exp_hi));
      end
      check_outputs("run1");

      // done holds and the bus stays quiet in DONE.
      repeat (3) @(negedge clk);
      check("done hold",  32'(done),          32'd1);
      check("done we",    32'(bus.mem_we),    32'd0);
      check("done addr",  32'(bus.mem_addr),  32'd0);
      check("done wdata", 32'(bus.mem_wdata), 32'd0);

      // Run 2: random data, restarted from DONE.
      load_random();
      run_engine(0, cycles);
      check("run2 latency", 32'(cycles), 32'(RUN_LEN));
      check_outputs("run2");

      // Run 3: second start at cycle 20 must not disturb the run.
      load_random();
      fill_out(8'hA5);
      run_engine(20, cycles);
      check("run3 latency", 32'(cycles), 32'(RUN_LEN));
      check_outputs("run3");

      // Run 4: reset during message 7 WR_LO aborts the run.
      load_random();
      fill_out(8'hA5);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      hit   = 1'b0;
      for (int n = 0; n < 4 * RUN_LEN && !hit; n++) begin
         @(negedge clk);
         if (bus.mem_we && bus.mem_addr == 8'(OUT_BASE + 14)) hit = 1'b1;
      end
      check("reach msg7 wr_lo", 32'(hit), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("abort done", 32'(done),         32'd0);
      check("abort we",   32'(bus.mem_we),   32'd0);
      check("abort addr", 32'(bus.mem_addr), 32'd0);
      w0 = wr_count;
      repeat (6) @(negedge clk);
      check("abort no writes", 32'(wr_count - w0), 32'd0);
      check("abort msg7 hi untouched", 32'(mem[OUT_BASE + 15]), 32'h0000_00A5);
      check("abort msg8 lo untouched", 32'(mem[OUT_BASE + 16]), 32'h0000_00A5);
      check("abort done idle", 32'(done), 32'd0);

      // Fresh run after the abort.
      run_engine(0, cycles);
      check("run5 latency", 32'(cycles), 32'(RUN_LEN));
      check_outputs("run5");

      // Round trip through a SECDED decoder using the engine's codewords.
      for (int i = 0; i < 4; i++) begin
         logic [15:0] cw;
         int          b1;
         int          b2;
         cw = {mem[OUT_BASE + 2 * i + 1], mem[OUT_BASE + 2 * i]};
         b1 = int'($urandom_range(15, 0));
         b2 = (b1 + 1 + int'($urandom_range(14, 0))) % 16;
         check($sformatf("rt1 msg%0d", i), 32'(ref_dec(cw ^ (16'd1 << b1))),
               32'({2'b01, 3'b000, msg[i]}));
         check($sformatf("rt2 msg%0d", i),
               32'(ref_dec(cw ^ (16'd1 << b1) ^ (16'd1 << b2)) >> 15), 32'd1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_hamming_enc_engine
